rv_branch_resolve: RTL and testbench

//  EX-stage branch/jump resolution unit; the producer side of the 2-bit dynamic predictor interface.

---
 rtl/rv_branch_resolve_pkg.sv | 14 +
 rtl/rv_branch_cmp.sv | 25 ++
 rtl/rv_branch_resolve.sv | 110 +++++++++++
 tb/tb_rv_branch_resolve.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rv_branch_resolve_pkg.sv
// rv_branch_resolve_pkg: shared funct3 branch codes, predictor index default and funct3 helper
package rv_branch_resolve_pkg;
  localparam int BPB_IDX_W_DEF = 4;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  // 010/011 are not branch encodings: never taken, never redirect
  function automatic logic f3_valid(input logic [2:0] f3);
    return f3[2] | ~f3[1];
  endfunction
endpackage

// File: rtl/rv_branch_cmp.sv
// rv_branch_cmp: combinational RV32I branch condition evaluator
// ports: rs1_i/rs2_i operands, funct3_i branch code, taken_o condition result
module rv_branch_cmp
  import rv_branch_resolve_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [2:0]      funct3_i,
  output logic            taken_o
);
  logic eq, lt, ltu;
  always_comb begin
    eq      = rs1_i == rs2_i;
    lt      = $signed(rs1_i) < $signed(rs2_i);
    ltu     = rs1_i < rs2_i;
    taken_o = (funct3_i == F3_BEQ)  ? eq   :
              (funct3_i == F3_BNE)  ? ~eq  :
              (funct3_i == F3_BLT)  ? lt   :
              (funct3_i == F3_BGE)  ? ~lt  :
              (funct3_i == F3_BLTU) ? ltu  :
              (funct3_i == F3_BGEU) ? ~ltu : 1'b0;
  end
endmodule

// File: rtl/rv_branch_resolve.sv
// rv_branch_resolve: EX-stage branch/jump resolution, predictor update and fetch redirect
// ports: clk/rstn; ID_* instruction fields into the ID/EX slot; EX_stall_i/EX_flush_i slot control;
//        EX_rs1_i/EX_rs2_i forwarded operands; EX_*_o predictor update; redirect_o/redirect_pc_o;
//        cnt_clr_i, br_cnt_o (conditional branches), mis_cnt_o (redirects)
module rv_branch_resolve
  import rv_branch_resolve_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BPB_IDX_W = BPB_IDX_W_DEF,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ID_valid_i,
  input  logic                 ID_branch_i,
  input  logic                 ID_jal_i,
  input  logic                 ID_jalr_i,
  input  logic [2:0]           ID_funct3_i,
  input  logic [XLEN-1:0]      ID_pc_i,
  input  logic [XLEN-1:0]      ID_imm_i,
  input  logic                 ID_predict_i,
  input  logic                 EX_stall_i,
  input  logic                 EX_flush_i,
  input  logic [XLEN-1:0]      EX_rs1_i,
  input  logic [XLEN-1:0]      EX_rs2_i,
  output logic                 EX_branch_o,
  output logic                 EX_taken_o,
  output logic                 EX_jal_o,
  output logic                 EX_jalr_o,
  output logic [BPB_IDX_W-1:0] EX_addr_o,
  output logic                 redirect_o,
  output logic [XLEN-1:0]      redirect_pc_o,
  input  logic                 cnt_clr_i,
  output logic [CNT_W-1:0]     br_cnt_o,
  output logic [CNT_W-1:0]     mis_cnt_o
);
  logic             v_q, br_q, jal_q, jalr_q, pred_q, done_q, squash_q;
  logic [2:0]       f3_q;
  logic [XLEN-1:0]  pc_q, imm_q, jalr_sum;
  logic [CNT_W-1:0] br_cnt_q, mis_cnt_q, br_cnt_d, mis_cnt_d;
  logic             fire, cmp_taken, taken, redirect;
  rv_branch_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1_i    (EX_rs1_i),
    .rs2_i    (EX_rs2_i),
    .funct3_i (f3_q),
    .taken_o  (cmp_taken)
  );
  // done suppresses a second update/redirect while the slot is held by a stall
  always_comb begin
    fire          = v_q & ~done_q & ~EX_flush_i;
    taken         = jal_q | jalr_q | (br_q & cmp_taken);
    redirect      = fire & (jal_q | jalr_q | (br_q & f3_valid(f3_q) & (cmp_taken ^ pred_q)));
    jalr_sum      = EX_rs1_i + imm_q;
    EX_branch_o   = fire & (br_q | jal_q | jalr_q);
    EX_taken_o    = fire & taken;
    EX_jal_o      = fire & jal_q;
    EX_jalr_o     = fire & jalr_q;
    EX_addr_o     = fire ? pc_q[BPB_IDX_W+1:2] : '0;
    redirect_o    = redirect;
    redirect_pc_o = ~redirect ? '0 :
                    jalr_q    ? {jalr_sum[XLEN-1:1], 1'b0} :
                    taken     ? pc_q + imm_q : pc_q + XLEN'(4);
    br_cnt_d      = cnt_clr_i ? '0 : (fire & br_q & ~&br_cnt_q) ? br_cnt_q + CNT_W'(1) : br_cnt_q;
    mis_cnt_d     = cnt_clr_i ? '0 : (redirect & ~&mis_cnt_q) ? mis_cnt_q + CNT_W'(1) : mis_cnt_q;
    br_cnt_o      = br_cnt_q;
    mis_cnt_o     = mis_cnt_q;
  end
  // squash remembers a redirect issued under stall so the wrong-path ID instruction enters as a bubble
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q       <= 1'b0;
      br_q      <= 1'b0;
      jal_q     <= 1'b0;
      jalr_q    <= 1'b0;
      pred_q    <= 1'b0;
      f3_q      <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      done_q    <= 1'b0;
      squash_q  <= 1'b0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      if (EX_flush_i) begin
        v_q    <= 1'b0;
        done_q <= 1'b0;
      end else if (EX_stall_i) begin
        done_q   <= done_q | fire;
        squash_q <= squash_q | redirect;
      end else if (redirect | squash_q) begin
        v_q      <= 1'b0;
        done_q   <= 1'b0;
        squash_q <= 1'b0;
      end else begin
        v_q      <= ID_valid_i;
        br_q     <= ID_branch_i;
        jal_q    <= ID_jal_i;
        jalr_q   <= ID_jalr_i;
        pred_q   <= ID_predict_i;
        f3_q     <= ID_funct3_i;
        pc_q     <= ID_pc_i;
        imm_q    <= ID_imm_i;
        done_q   <= 1'b0;
        squash_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rv_branch_resolve.sv
// tb_rv_branch_resolve: directed self-checking bench for rv_branch_resolve (CNT_W=4 build)
module tb_rv_branch_resolve;
  logic        clk = 1'b0;
  logic        rstn;
  logic        ID_valid_i, ID_branch_i, ID_jal_i, ID_jalr_i, ID_predict_i;
  logic [2:0]  ID_funct3_i;
  logic [31:0] ID_pc_i, ID_imm_i, EX_rs1_i, EX_rs2_i;
  logic        EX_stall_i, EX_flush_i, cnt_clr_i;
  logic        EX_branch_o, EX_taken_o, EX_jal_o, EX_jalr_o, redirect_o;
  logic [3:0]  EX_addr_o, br_cnt_o, mis_cnt_o;
  logic [31:0] redirect_pc_o;
  int          passes = 0;
  int          total  = 0;
  rv_branch_resolve #(.XLEN(32), .BPB_IDX_W(4), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn),
    .ID_valid_i(ID_valid_i), .ID_branch_i(ID_branch_i), .ID_jal_i(ID_jal_i), .ID_jalr_i(ID_jalr_i),
    .ID_funct3_i(ID_funct3_i), .ID_pc_i(ID_pc_i), .ID_imm_i(ID_imm_i), .ID_predict_i(ID_predict_i),
    .EX_stall_i(EX_stall_i), .EX_flush_i(EX_flush_i), .EX_rs1_i(EX_rs1_i), .EX_rs2_i(EX_rs2_i),
    .EX_branch_o(EX_branch_o), .EX_taken_o(EX_taken_o), .EX_jal_o(EX_jal_o), .EX_jalr_o(EX_jalr_o),
    .EX_addr_o(EX_addr_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .cnt_clr_i(cnt_clr_i), .br_cnt_o(br_cnt_o), .mis_cnt_o(mis_cnt_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic issue(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    ID_valid_i = 1'b1; ID_branch_i = br; ID_jal_i = jal; ID_jalr_i = jalr;
    ID_funct3_i = f3; ID_pc_i = pc; ID_imm_i = imm; ID_predict_i = pred;
    @(posedge clk); #1;
    ID_valid_i = 1'b0;
  endtask
  initial begin
    rstn = 1'b0; ID_valid_i = 0; ID_branch_i = 0; ID_jal_i = 0; ID_jalr_i = 0; ID_predict_i = 0;
    ID_funct3_i = 0; ID_pc_i = 0; ID_imm_i = 0; EX_rs1_i = 0; EX_rs2_i = 0;
    EX_stall_i = 0; EX_flush_i = 0; cnt_clr_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_branch", EX_branch_o, 0);
    chk("rst_redirect", redirect_o, 0);
    chk("rst_redirect_pc", redirect_pc_o, 0);
    chk("rst_br_cnt", br_cnt_o, 0);
    chk("rst_mis_cnt", mis_cnt_o, 0);
    rstn = 1'b1;
    // BEQ taken, predicted not taken
    issue(1, 0, 0, 3'b000, 32'h100, 32'h20, 0);
    EX_rs1_i = 5; EX_rs2_i = 5; #1;
    chk("beq_branch", EX_branch_o, 1);
    chk("beq_taken", EX_taken_o, 1);
    chk("beq_redirect", redirect_o, 1);
    chk("beq_pc", redirect_pc_o, 32'h120);
    chk("beq_addr", EX_addr_o, 0);
    @(posedge clk); #1;
    chk("beq_mis_cnt", mis_cnt_o, 1);
    chk("beq_br_cnt", br_cnt_o, 1);
    // BNE not taken, predicted taken; wrong-path ID instruction must become a bubble
    issue(1, 0, 0, 3'b001, 32'h40, 32'h8, 1);
    ID_valid_i = 1; ID_branch_i = 1; ID_funct3_i = 3'b000; ID_pc_i = 32'h80; ID_predict_i = 0;
    EX_rs1_i = 7; EX_rs2_i = 7; #1;
    chk("bne_taken", EX_taken_o, 0);
    chk("bne_redirect", redirect_o, 1);
    chk("bne_pc", redirect_pc_o, 32'h44);
    @(posedge clk); #1;
    chk("bne_bubble", EX_branch_o, 0);
    chk("bne_bubble_redirect", redirect_o, 0);
    chk("bne_mis_cnt", mis_cnt_o, 2);
    ID_valid_i = 0;
    cnt_clr_i = 1;
    @(posedge clk); #1;
    cnt_clr_i = 0;
    chk("clr_br_cnt", br_cnt_o, 0);
    chk("clr_mis_cnt", mis_cnt_o, 0);
    // BLT taken vs BLTU not taken on the same operands, both correctly predicted
    issue(1, 0, 0, 3'b100, 32'h200, 32'h40, 1);
    EX_rs1_i = 32'hFFFF_FFFF; EX_rs2_i = 1; #1;
    chk("blt_taken", EX_taken_o, 1);
    chk("blt_redirect", redirect_o, 0);
    issue(1, 0, 0, 3'b110, 32'h204, 32'h40, 0);
    #1;
    chk("bltu_taken", EX_taken_o, 0);
    chk("bltu_redirect", redirect_o, 0);
    chk("bltu_addr", EX_addr_o, 1);
    // funct3 010: never taken, no redirect even when predicted taken
    issue(1, 0, 0, 3'b010, 32'h208, 32'h40, 1);
    #1;
    chk("lt_pair_br_cnt", br_cnt_o, 2);
    chk("lt_pair_mis_cnt", mis_cnt_o, 0);
    chk("f3_010_branch", EX_branch_o, 1);
    chk("f3_010_taken", EX_taken_o, 0);
    chk("f3_010_redirect", redirect_o, 0);
    @(posedge clk); #1;
    chk("f3_010_br_cnt", br_cnt_o, 3);
    // JALR under a 3-cycle stall
    issue(0, 0, 1, 3'b000, 32'h300, 32'h4, 0);
    ID_valid_i = 1; ID_branch_i = 1; ID_funct3_i = 3'b000; ID_pc_i = 32'h304; ID_predict_i = 0;
    EX_stall_i = 1; EX_rs1_i = 32'h1003; EX_rs2_i = 32'h1003; #1;
    chk("jalr_redirect", redirect_o, 1);
    chk("jalr_o", EX_jalr_o, 1);
    chk("jalr_pc", redirect_pc_o, 32'h1006);
    chk("jalr_taken", EX_taken_o, 1);
    chk("jalr_branch", EX_branch_o, 1);
    @(posedge clk); #1;
    chk("jalr_stall1_redirect", redirect_o, 0);
    chk("jalr_stall1_jalr", EX_jalr_o, 0);
    chk("jalr_mis_cnt", mis_cnt_o, 1);
    @(posedge clk); #1;
    chk("jalr_stall2_redirect", redirect_o, 0);
    EX_stall_i = 0;
    @(posedge clk); #1;
    chk("jalr_release_bubble", EX_branch_o, 0);
    chk("jalr_release_redirect", redirect_o, 0);
    chk("jalr_final_mis_cnt", mis_cnt_o, 1);
    chk("jalr_final_br_cnt", br_cnt_o, 3);
    ID_valid_i = 0;
    // external flush of a mispredicting branch
    issue(1, 0, 0, 3'b000, 32'h400, 32'h10, 0);
    EX_flush_i = 1; EX_rs1_i = 5; EX_rs2_i = 5; #1;
    chk("flush_redirect", redirect_o, 0);
    chk("flush_branch", EX_branch_o, 0);
    @(posedge clk); #1;
    EX_flush_i = 0; #1;
    chk("flush_branch_after", EX_branch_o, 0);
    chk("flush_br_cnt", br_cnt_o, 3);
    chk("flush_mis_cnt", mis_cnt_o, 1);
    // drive both counters to all-ones with mispredicting BEQs
    for (int i = 0; i < 14; i++) begin
      issue(1, 0, 0, 3'b000, 32'h500, 32'h10, 0);
      @(posedge clk); #1;
    end
    chk("fill_br_cnt", br_cnt_o, 4'hF);
    chk("fill_mis_cnt", mis_cnt_o, 4'hF);
    issue(1, 0, 0, 3'b000, 32'h500, 32'h10, 0);
    chk("sat_redirect", redirect_o, 1);
    @(posedge clk); #1;
    chk("sat_br_cnt", br_cnt_o, 4'hF);
    chk("sat_mis_cnt", mis_cnt_o, 4'hF);
    issue(1, 0, 0, 3'b000, 32'h500, 32'h10, 0);
    cnt_clr_i = 1;
    @(posedge clk); #1;
    cnt_clr_i = 0;
    chk("clr_win_br_cnt", br_cnt_o, 0);
    chk("clr_win_mis_cnt", mis_cnt_o, 0);
    // reset in the middle of a stalled JALR
    issue(0, 0, 1, 3'b000, 32'h600, 32'h8, 0);
    EX_stall_i = 1; #1;
    chk("rst_mid_redirect_before", redirect_o, 1);
    @(posedge clk); #2;
    rstn = 0; #1;
    chk("rst_mid_redirect", redirect_o, 0);
    chk("rst_mid_jalr", EX_jalr_o, 0);
    chk("rst_mid_mis_cnt", mis_cnt_o, 0);
    @(posedge clk); #1;
    rstn = 1;
    @(posedge clk); #1;
    chk("rst_after_redirect", redirect_o, 0);
    chk("rst_after_branch", EX_branch_o, 0);
    EX_stall_i = 0;
    @(posedge clk); #1;
    chk("rst_after_release", redirect_o, 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
